// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants and helpers, also used by the downstream scan-code decoder.
package ps2_pkg;

    localparam int         FRAME_BITS = 11;
    localparam logic       START_BIT  = 1'b0;
    localparam logic       STOP_BIT   = 1'b1;
    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_PREFIX = 8'hE0;

    // Odd parity holds when the data bits together with the parity bit contain an odd number of ones.
    function automatic logic parity_odd(input logic [7:0] d, input logic p);
        return (^{d, p}) == 1'b1;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Byte FIFO with a registered head byte that keeps its last value when the FIFO is empty.
module ps2_byte_fifo #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   count_q, count_d, remain_s;
    logic [7:0]    head_q, head_d;
    logic          empty_q, full_q;
    logic          pop_ok_s, push_ok_s;

    // A pop frees a slot before the push is judged, so a full FIFO accepts a push that coincides with a pop.
    always_comb begin
        pop_ok_s  = pop_i & (count_q != '0);
        push_ok_s = push_i & ((count_q != DEPTH_C) | pop_ok_s);
        rd_d      = rd_q + AW'(pop_ok_s);
        wr_d      = wr_q + AW'(push_ok_s);
        remain_s  = count_q - (AW + 1)'(pop_ok_s);
        count_d   = remain_s + (AW + 1)'(push_ok_s);
        if (count_d == '0) begin
            head_d = head_q;
        end else if (remain_s == '0) begin
            head_d = wdata_i;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    // Storage array; its contents are only read once written, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    // Pointers, occupancy, status flags and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            head_q  <= 8'h00;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            head_q  <= head_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == DEPTH_C);
        end
    end

    assign head_o  = head_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign count_o = count_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the bus, deserialises and checks frames,
// and buffers good bytes for the scan-code decoder behind a ready/nextdata_n pop handshake.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               nextdata_n,
    output logic [7:0]         data,
    output logic               ready,
    output logic               overflow,
    output logic               frame_err,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int             TO_W     = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]     LAST_BIT = 4'(FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [8:0]             shift_q, shift_d;
    logic [TO_W-1:0]        to_q, to_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_err_q;
    logic                   fall_s, bit_s, push_s, bad_s, drop_s, pop_ok_s;
    logic                   fifo_empty_s, fifo_full_s;

    // Both chains have equal depth so the data sample lines up with the detected clock edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign fall_s = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
    assign bit_s  = data_sync_q[SYNC_STAGES-2];

    // Frame deserialiser and mid-frame timeout; shift_q collects data bits 0..7 then parity.
    always_comb begin
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        to_d     = to_q;
        push_s   = 1'b0;
        bad_s    = 1'b0;
        if (fall_s) begin
            to_d = '0;
            if (bitcnt_q == 4'd0) begin
                if (bit_s == START_BIT) begin
                    bitcnt_d = 4'd1;
                end else begin
                    bitcnt_d = 4'd0;
                end
            end else if (bitcnt_q == LAST_BIT) begin
                bitcnt_d = 4'd0;
                shift_d  = '0;
                if ((bit_s == STOP_BIT) && parity_odd(shift_q[7:0], shift_q[8])) begin
                    push_s = 1'b1;
                end else begin
                    bad_s = 1'b1;
                end
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
                shift_d  = {bit_s, shift_q[8:1]};
            end
        end else if (bitcnt_q != 4'd0) begin
            if (to_q == TO_LAST) begin
                bitcnt_d = 4'd0;
                shift_d  = '0;
                to_d     = '0;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end else begin
            to_d = '0;
        end
    end

    // A full FIFO is always non-empty, so any pop request then succeeds and makes room.
    always_comb begin
        pop_ok_s = ~nextdata_n & ~fifo_empty_s;
        drop_s   = push_s & fifo_full_s & nextdata_n;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (pop_ok_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Receiver state and status registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bitcnt_q    <= 4'd0;
            shift_q     <= '0;
            to_q        <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            to_q        <= to_d;
            overflow_q  <= overflow_d;
            frame_err_q <= bad_s;
        end
    end

    ps2_byte_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (clrn),
        .push_i  (push_s),
        .wdata_i (shift_q[7:0]),
        .pop_i   (~nextdata_n),
        .head_o  (data),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s),
        .count_o (fifo_count)
    );

    assign ready     = ~fifo_empty_s;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
